instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 156 +++++++++++++++
 tb/tb_instr_fetch.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: fetches one word, holds it for decode, then resolves the next PC.
// Optional FETCH_ALIGN_CHECK_EN: a misaligned target raises fetch_err and halts until reset.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        resolve,
  input  logic        branch,
  input  logic        jump,
  input  logic        is_jal,
  input  logic        is_jr,
  input  logic [2:0]  branchType,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        taken,
  output logic [31:0] next_pc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic        instr_valid_reg;
  logic        imem_req_reg;
  logic        taken_reg;
  logic [31:0] next_pc_reg;

  logic        cond_true;
  logic        taken_next;
  logic [31:0] branch_off;
  logic [31:0] target_raw;
  logic [31:0] next_pc_next;
  logic        misaligned;

  // The link value is pc_plus4 itself, so is_jal never changes the target.
  logic unused_is_jal;
  assign unused_is_jal = is_jal;

  assign pc_plus4   = pc_reg + 32'd4;
  assign branch_off = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};

  always_comb begin
    cond_true = 1'b0;
    case (branchType)
      3'b000: cond_true = (rs_val == rt_val);
      3'b001: cond_true = (rs_val != rt_val);
      3'b010: cond_true = ($signed(rs_val) >  $signed(rt_val));
      3'b011: cond_true = ($signed(rs_val) >= $signed(rt_val));
      3'b100: cond_true = ($signed(rs_val) <  $signed(rt_val));
      3'b101: cond_true = ($signed(rs_val) <= $signed(rt_val));
      3'b110: cond_true = (rs_val <= rt_val);
      default: cond_true = (rs_val > rt_val);
    endcase
  end

  always_comb begin
    target_raw = pc_plus4;
    taken_next = 1'b0;
    if (is_jr) begin
      target_raw = rs_val;
      taken_next = 1'b1;
    end else if (jump) begin
      target_raw = {pc_plus4[31:28], instr_reg[25:0], 2'b00};
      taken_next = 1'b1;
    end else if (branch && cond_true) begin
      target_raw = pc_plus4 + branch_off;
      taken_next = 1'b1;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic fetch_err_reg;
  assign next_pc_next = target_raw;
  assign misaligned   = (target_raw[1:0] != 2'b00);
  assign fetch_err    = fetch_err_reg;
`else
  assign next_pc_next = {target_raw[31:2], 2'b00};
  assign misaligned   = 1'b0;
  assign fetch_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      instr_reg       <= 32'd0;
      instr_valid_reg <= 1'b0;
      imem_req_reg    <= 1'b0;
      taken_reg       <= 1'b0;
      next_pc_reg     <= 32'd0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_err_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg    <= FETCH;
          imem_req_reg <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            instr_reg       <= imem_rdata;
            instr_valid_reg <= 1'b1;
            imem_req_reg    <= 1'b0;
            state_reg       <= HOLD;
          end
        end
        HOLD: begin
          if (resolve) begin
            taken_reg       <= taken_next;
            next_pc_reg     <= next_pc_next;
            instr_valid_reg <= 1'b0;
            if (misaligned) begin
              // Bad target: stop requesting until the next reset.
              state_reg     <= HALT;
`ifdef FETCH_ALIGN_CHECK_EN
              fetch_err_reg <= 1'b1;
`endif
            end else begin
              pc_reg       <= next_pc_next;
              imem_req_reg <= 1'b1;
              state_reg    <= FETCH;
            end
          end
        end
        default: begin
          imem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_reg;
  assign imem_addr   = pc_reg;
  assign instr       = instr_reg;
  assign opcode      = instr_reg[31:26];
  assign funct       = instr_reg[5:0];
  assign instr_valid = instr_valid_reg;
  assign pc_out      = pc_reg;
  assign taken       = taken_reg;
  assign next_pc     = next_pc_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, streaming fetch, branch/jump resolution, wrap, reset mid-fetch.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        resolve;
  logic        branch;
  logic        jump;
  logic        is_jal;
  logic        is_jr;
  logic [2:0]  branchType;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        taken;
  logic [31:0] next_pc;
  logic        fetch_err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .funct(funct),
    .instr_valid(instr_valid), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .resolve(resolve), .branch(branch), .jump(jump), .is_jal(is_jal), .is_jr(is_jr),
    .branchType(branchType), .rs_val(rs_val), .rt_val(rt_val),
    .taken(taken), .next_pc(next_pc), .fetch_err(fetch_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_ctrl();
    resolve = 1'b0; branch = 1'b0; jump = 1'b0; is_jal = 1'b0; is_jr = 1'b0;
    branchType = 3'b000; rs_val = 32'd0; rt_val = 32'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},     {31'd0, imem_req},    32'd0);
    check({tag, "_addr"},    imem_addr,            32'd0);
    check({tag, "_instr"},   instr,                32'd0);
    check({tag, "_valid"},   {31'd0, instr_valid}, 32'd0);
    check({tag, "_taken"},   {31'd0, taken},       32'd0);
    check({tag, "_next_pc"}, next_pc,              32'd0);
    check({tag, "_err"},     {31'd0, fetch_err},   32'd0);
  endtask

  // Waits (bounded) for a request, checks its address, returns the word with ready.
  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] word);
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fetch_req_seen", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, exp_addr);
    imem_ready = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    check("hold_valid", {31'd0, instr_valid}, 32'd1);
    check("hold_instr", instr, word);
    check("hold_pc_plus4", pc_plus4, exp_addr + 32'd4);
    $display("[TB] fetch addr=0x%08h word=0x%08h", imem_addr, instr);
  endtask

  task automatic do_resolve(input logic br, input logic jmp, input logic jal, input logic jr,
                            input logic [2:0] bt, input logic [31:0] rs, input logic [31:0] rt,
                            input logic exp_taken, input logic [31:0] exp_next);
    branch = br; jump = jmp; is_jal = jal; is_jr = jr; branchType = bt;
    rs_val = rs; rt_val = rt; resolve = 1'b1;
    @(negedge clk);
    clear_ctrl();
    check("res_taken", {31'd0, taken}, {31'd0, exp_taken});
    check("res_next_pc", next_pc, exp_next);
    check("res_valid_low", {31'd0, instr_valid}, 32'd0);
    $display("[TB] resolve taken=%0b next_pc=0x%08h", taken, next_pc);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_release_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'd0);
    $display("[TB] reset released, first request at 0x%08h", imem_addr);
  endtask

  initial begin
    rst_n = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    clear_ctrl();
    #2;
    apply_reset();

    // Streaming: ready and resolve held high, no controls -> 2 cycles per instruction.
    imem_ready = 1'b1;
    resolve = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stream_req", {31'd0, imem_req}, 32'd1);
      check("stream_addr", imem_addr, 32'(i * 4));
      $display("[TB] stream fetch addr=0x%08h", imem_addr);
      @(negedge clk);
      check("stream_hold_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
    end
    imem_ready = 1'b0;
    resolve = 1'b0;

    @(negedge clk);
    apply_reset();

    // j to 0x10
    do_fetch(32'h0, 32'h0800_0004);
    check("opcode_j", {26'd0, opcode}, 32'h02);
    // imem_ready during HOLD must not disturb the held word
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ready = 1'b0; imem_rdata = 32'd0;
    check("ignore_ready_instr", instr, 32'h0800_0004);
    check("ignore_ready_valid", {31'd0, instr_valid}, 32'd1);
    do_resolve(0, 1, 0, 0, 3'b000, 0, 0, 1'b1, 32'h10);

    // beq back 2 words
    do_fetch(32'h10, 32'h1000_FFFE);
    do_resolve(1, 0, 0, 0, 3'b000, 32'd5, 32'd5, 1'b1, 32'h0C);

    // bgtu taken, then bgt not taken with the same operands
    do_fetch(32'h0C, 32'h1C00_0004);
    do_resolve(1, 0, 0, 0, 3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h20);
    do_fetch(32'h20, 32'h1C00_0004);
    do_resolve(1, 0, 0, 0, 3'b010, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h24);

    // blt signed -1 < 1, offset -1 word
    do_fetch(32'h24, 32'h0400_FFFF);
    do_resolve(1, 0, 0, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h24);

    // jr to 0x2000_0040, then jal there
    do_fetch(32'h24, 32'h0000_0008);
    check("funct_jr", {26'd0, funct}, 32'h08);
    do_resolve(0, 0, 0, 1, 3'b000, 32'h2000_0040, 0, 1'b1, 32'h2000_0040);
    do_fetch(32'h2000_0040, 32'h0C00_0100);
    check("jal_pc_plus4", pc_plus4, 32'h2000_0044);
    do_resolve(0, 1, 1, 0, 3'b000, 0, 0, 1'b1, 32'h2000_0400);

    // PC wrap
    do_fetch(32'h2000_0400, 32'h0000_0008);
    do_resolve(0, 0, 0, 1, 3'b000, 32'hFFFF_FFFC, 0, 1'b1, 32'hFFFF_FFFC);
    do_fetch(32'hFFFF_FFFC, 32'h0000_0000);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    do_resolve(0, 0, 0, 0, 3'b000, 0, 0, 1'b0, 32'h0);

    // misaligned jr target
    do_fetch(32'h0, 32'h0000_0008);
`ifdef FETCH_ALIGN_CHECK_EN
    do_resolve(0, 0, 0, 1, 3'b000, 32'h102, 0, 1'b1, 32'h102);
    check("align_err", {31'd0, fetch_err}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("halt_no_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
    end
    $display("[TB] halted with fetch_err=%0b", fetch_err);
`else
    do_resolve(0, 0, 0, 1, 3'b000, 32'h102, 0, 1'b1, 32'h100);
    check("align_no_err", {31'd0, fetch_err}, 32'd0);
    check("align_req", {31'd0, imem_req}, 32'd1);
    check("align_addr", imem_addr, 32'h100);
    $display("[TB] aligned restart at 0x%08h", imem_addr);
`endif

    // Reset pulsed mid-cycle while fetching (or halted) with imem_ready low
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    check("midreset_pc", pc_out, 32'h0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("restart_req", {31'd0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, 32'h0);
    $display("[TB] restart after mid-fetch reset at 0x%08h", imem_addr);
    do_fetch(32'h0, 32'h0000_0000);
    do_resolve(0, 0, 0, 0, 3'b000, 0, 0, 1'b0, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
